// File: rtl/dds_pkg.sv
// Shared DDS definitions: datapath widths, unity gain and the Q0.16 rounding
// shift used by the AM/FM/PM lookup readers.
package dds_pkg;

  localparam int PHASE_W     = 32;
  localparam int LUT_ADDR_W  = 10;
  localparam int LUT_DATA_W  = 16;
  localparam int SAMPLE_W    = 14;

  // Signed carrier x unsigned Q0.16 gain fits in PHASE_W-2 bits.
  localparam int PROD_W      = PHASE_W - 2;
  localparam int GAIN_FRAC_W = LUT_DATA_W;

  localparam logic [LUT_DATA_W-1:0] UNITY_GAIN = 16'hFFFF;
  localparam logic signed [PROD_W:0] ROUND_BIAS = (PROD_W + 1)'(1 << (GAIN_FRAC_W - 1));

  // Round-half-up then drop the gain fraction; magnitude never exceeds the carrier.
  function automatic logic signed [SAMPLE_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [PROD_W:0] biased;
    logic signed [PROD_W:0] shifted;
    biased  = $signed({prod[PROD_W-1], prod}) + ROUND_BIAS;
    shifted = biased >>> GAIN_FRAC_W;
    return $signed(shifted[SAMPLE_W-1:0]);
  endfunction

endpackage

// File: rtl/dds_phase_accumulator.sv
// Modulation phase accumulator with clear-over-advance priority; exposes the
// top bits as the lookup-table address.
module dds_phase_accumulator
  import dds_pkg::*;
#(
  parameter int ACC_W  = PHASE_W,
  parameter int ADDR_W = LUT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              advance,
  input  logic [ACC_W-1:0]  inc,
  output logic [ADDR_W-1:0] addr
);

  logic [ACC_W-1:0] acc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (advance) begin
      acc <= acc + inc;
    end
  end

  assign addr = acc[ACC_W-1 -: ADDR_W];

endmodule

// File: rtl/dds_am_table_reader.sv
// DDS channel-0 AM reader: walks the envelope RAM with a phase accumulator and
// scales each carrier sample by the fetched Q0.16 gain (3-cycle pipeline).
module dds_am_table_reader
  import dds_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       am_enable,
  input  logic [PHASE_W-1:0]         phase_inc,
  input  logic                       phase_clr,
  input  logic                       car_valid,
  input  logic [SAMPLE_W-1:0]        car_data,
  output logic [LUT_ADDR_W-1:0]      ram_address,
  output logic                       ram_chipselect,
  output logic                       ram_write,
  output logic [1:0]                 ram_byteenable,
  output logic [LUT_DATA_W-1:0]      ram_writedata,
  input  logic [LUT_DATA_W-1:0]      ram_readdata,
  output logic                       out_valid,
  output logic [SAMPLE_W-1:0]        out_data
);

  logic                       s1_v;
  logic signed [SAMPLE_W-1:0] s1_car;
  logic                       s2_v;
  logic signed [PROD_W-1:0]   s2_prod;
  logic [LUT_DATA_W-1:0]      gain;
  logic signed [PROD_W-1:0]   prod;

  // The address presented now is the pre-update accumulator, so a sample
  // accepted together with phase_clr still reads the old location.
  dds_phase_accumulator #(
    .ACC_W  (PHASE_W),
    .ADDR_W (LUT_ADDR_W)
  ) u_phase_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (phase_clr),
    .advance (car_valid & am_enable),
    .inc     (phase_inc),
    .addr    (ram_address)
  );

  assign ram_chipselect = car_valid;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 2'b11;
  assign ram_writedata  = '0;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    gain = UNITY_GAIN;
    if (am_enable) begin
      gain = ram_readdata;
    end
  end

  // Gain is zero-extended so it multiplies as an unsigned quantity.
  assign prod = $signed({{(PROD_W - SAMPLE_W){s1_car[SAMPLE_W-1]}}, s1_car})
              * $signed({{(PROD_W - LUT_DATA_W){1'b0}}, gain});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v      <= 1'b0;
      s1_car    <= '0;
      s2_v      <= 1'b0;
      s2_prod   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      s1_v      <= car_valid;
      s2_v      <= s1_v;
      out_valid <= s2_v;
      if (car_valid) begin
        s1_car <= $signed(car_data);
      end
      if (s1_v) begin
        s2_prod <= prod;
      end
      if (s2_v) begin
        out_data <= round_shift(s2_prod);
      end
    end
  end

endmodule

// File: tb/tb_dds_am_table_reader.sv
// Randomized scoreboard bench for dds_am_table_reader with a behavioural RAM
// and a real-arithmetic reference for the modulated output.
module tb_dds_am_table_reader;
  import dds_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  am_enable = 1'b0;
  logic [PHASE_W-1:0]    phase_inc = '0;
  logic                  phase_clr = 1'b0;
  logic                  car_valid = 1'b0;
  logic [SAMPLE_W-1:0]   car_data = '0;
  logic [LUT_ADDR_W-1:0] ram_address;
  logic                  ram_chipselect;
  logic                  ram_write;
  logic [1:0]            ram_byteenable;
  logic [LUT_DATA_W-1:0] ram_writedata;
  logic [LUT_DATA_W-1:0] ram_readdata;
  logic                  out_valid;
  logic [SAMPLE_W-1:0]   out_data;

  dds_am_table_reader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .am_enable      (am_enable),
    .phase_inc      (phase_inc),
    .phase_clr      (phase_clr),
    .car_valid      (car_valid),
    .car_data       (car_data),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_readdata   (ram_readdata),
    .out_valid      (out_valid),
    .out_data       (out_data)
  );

  always #5 clk = ~clk;

  // Envelope RAM second port: address registered on the edge, data unregistered.
  logic [LUT_DATA_W-1:0] table_mem [1024];
  logic [LUT_ADDR_W-1:0] ram_addr_q = '0;
  always @(posedge clk) ram_addr_q <= ram_address;
  assign ram_readdata = table_mem[ram_addr_q];

  typedef struct {
    longint value;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;

  always @(posedge clk) cyc++;

  // Reference model state: phase accumulator and the sample waiting for its gain.
  logic [31:0] m_acc = '0;
  bit          p_v = 1'b0;
  longint      p_car = 0;
  int          p_addr = 0;
  longint      p_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Carrier times Q0.16 gain, rounded to nearest with halves going up.
  function automatic longint ref_out(input longint car, input longint gain);
    real scaled;
    scaled = (real'(car) * real'(gain)) / 65536.0;
    return longint'($floor(scaled + 0.5));
  endfunction

  // One clock of stimulus; called #1 after a rising edge.
  task automatic step(input bit v, input int car, input bit en,
                      input logic [31:0] inc, input bit clr);
    car_valid = v;
    car_data  = car[SAMPLE_W-1:0];
    am_enable = en;
    phase_inc = inc;
    phase_clr = clr;
    // am_enable seen at the edge after acceptance decides the previous sample's gain.
    if (p_v)
      sb.push_back('{ref_out(p_car, en ? longint'(table_mem[p_addr]) : 65535), p_cyc});
    check("ram_address", longint'(ram_address), longint'(m_acc[31:22]));
    check("ram_chipselect", longint'(ram_chipselect), longint'(v));
    p_v    = v;
    p_car  = car;
    p_addr = int'(m_acc[31:22]);
    p_cyc  = cyc + 3;
    if (clr) m_acc = '0;
    else if (v && en) m_acc = m_acc + inc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, am_enable, phase_inc, 1'b0);
  endtask

  function automatic int rand_car();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got out_data %0d, expected no output (cycle %0d)",
                 $signed(out_data), cyc);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", longint'($signed(out_data)), mon_e.value);
        check("out_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) table_mem[i] = '0;

    // Reset state and constant RAM controls.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_ram_address", longint'(ram_address), 0);
    check("ram_write", longint'(ram_write), 0);
    check("ram_byteenable", longint'(ram_byteenable), 3);
    check("ram_writedata", longint'(ram_writedata), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Bypass: full ramp at unity gain, phase frozen at 0.
    for (int c = -8192; c <= 8191; c++) step(1'b1, c, 1'b0, $urandom, 1'b0);
    idle(4);

    // Constant half-scale envelope at both carrier extremes.
    for (int i = 0; i < 1024; i++) table_mem[i] = 16'h8000;
    for (int i = 0; i < 4; i++) step(1'b1, 8191, 1'b1, $urandom, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, -8192, 1'b1, $urandom, 1'b0);
    idle(4);

    // Address stepping with wrap past 1024 samples.
    for (int i = 0; i < 1024; i++) table_mem[i] = 16'(i);
    step(1'b0, 0, 1'b1, 32'h0040_0000, 1'b1);
    for (int i = 0; i < 1030; i++) step(1'b1, rand_car(), 1'b1, 32'h0040_0000, 1'b0);
    idle(4);

    // Clear on the 5th valid, then one-valid/two-idle bubbles.
    for (int i = 0; i < 1024; i++) table_mem[i] = 16'($urandom);
    step(1'b0, 0, 1'b1, 32'h0040_0000, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) check("clr_addr_5th", longint'(ram_address), 4);
      if (i == 6) check("clr_addr_6th", longint'(ram_address), 0);
      step(1'b1, rand_car(), 1'b1, 32'h0040_0000, i == 5);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, rand_car(), 1'b1, $urandom, 1'b0);
      idle(2);
    end
    idle(4);

    // Random traffic: gaps, enable toggling, clears, random tuning words.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_car(), $urandom_range(0, 3) != 0,
           $urandom, $urandom_range(0, 49) == 0);
    idle(4);

    // Reset with three samples in flight.
    table_mem[0] = 16'hC000;
    for (int i = 0; i < 3; i++) step(1'b1, rand_car(), 1'b1, $urandom, 1'b0);
    car_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_data", longint'(out_data), 0);
    sb.delete();
    p_v   = 1'b0;
    m_acc = '0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    step(1'b1, 8191, 1'b1, 32'h0040_0000, 1'b0);
    step(1'b1, -8192, 1'b1, 32'h0040_0000, 1'b0);
    idle(6);

    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dds_am_table_reader.md
# dds_am_table_reader

Read-side engine for the DDS channel-0 AM lookup RAM. The CPU loads a 1024×16 amplitude envelope through the RAM's Avalon port; this block owns the RAM's second port and never writes it. It runs a modulation phase accumulator, fetches one envelope word per incoming carrier sample, and multiplies the signed carrier by the unsigned gain (Q0.16). It sits between the DDS carrier generator and the DAC output stage.

## Interface
- PHASE_W, 32: modulation phase accumulator width.
- LUT_ADDR_W, 10: envelope RAM address width; the address is the accumulator's top LUT_ADDR_W bits.
- LUT_DATA_W, 16: envelope word width, unsigned Q0.16 gain.
- SAMPLE_W, 14: carrier and output sample width, two's complement.
- clk  in  1  single clock; the RAM's second port is on this same clock.
- reset_n  in  1  asynchronous, active-low reset.
- am_enable  in  1  1 = modulate and advance the phase; 0 = bypass with unity gain and phase frozen.
- phase_inc  in  PHASE_W  modulation tuning word; sampled once per accepted carrier sample.
- phase_clr  in  1  synchronous one-cycle pulse that zeroes the accumulator.
- car_valid  in  1  carrier sample strobe; may be high every cycle.
- car_data  in  SAMPLE_W  carrier sample.
- ram_address  out  LUT_ADDR_W  equals acc[PHASE_W-1 -: LUT_ADDR_W]; the RAM registers it every edge.
- ram_chipselect  out  1  equals car_valid.
- ram_write  out  1  constant 0.
- ram_byteenable  out  2  constant 2'b11.
- ram_writedata  out  LUT_DATA_W  constant 0.
- ram_readdata  in  LUT_DATA_W  unregistered RAM output, valid one cycle after the address edge.
- out_valid  out  1  output sample strobe.
- out_data  out  SAMPLE_W  modulated sample.

## Operation
- Reset values: acc = 0, all pipeline valids = 0, out_valid = 0, out_data = 0, and therefore ram_address = 0.
- Pipeline, with edge E0 being the edge where car_valid = 1:
  - E0: the RAM latches ram_address (the pre-update acc). The block registers s1_car = car_data and s1_v = 1.
  - E1: s2_prod = s1_car × g, a signed product of PHASE_W-2 = 30 bits. g = ram_readdata when am_enable = 1, else 16'hFFFF. s2_v is registered from s1_v.
  - E2: out_data = (s2_prod + 2^15) >>> 16, arithmetic shift, truncated to SAMPLE_W. out_valid is registered from s2_v.
- No saturation is needed: |out| ≤ |car|, and the full range −8192..8191 is representable.
- The g = 16'hFFFF bypass reproduces car_data exactly for every 14-bit input.
- The am_enable value used is the one sampled at E1; it applies to the sample in s1.
- Accumulator update at each edge, in priority order:
  1. phase_clr → acc = 0.
  2. car_valid & am_enable → acc = acc + phase_inc, modulo 2^PHASE_W with natural wrap.
  3. Otherwise acc holds.
- phase_clr together with car_valid: that sample uses the old address, the accumulator becomes 0, and the next sample reads address 0.
- Gaps in car_valid propagate as bubbles; output order and spacing mirror the input exactly.
- A CPU write to the RAM location being read in the same cycle has undefined mixed-port data. Only that one output sample is affected; the block takes no other action.
- reset_n assertion mid-stream: all in-flight samples are discarded immediately and asynchronously; no partial output appears after release.

## Timing
- Latency: car_valid in cycle N → out_valid in cycle N+3.
- Throughput: one sample per clock, sustained, with no backpressure; the downstream DAC is always ready.
- Every output is registered except the ram_* outputs. ram_address comes straight from the acc register; the other ram_* outputs are constants or equal car_valid.
- Critical path: 14×16 multiply from ram_readdata into s2_prod. This is one full cycle, since the RAM output is unregistered.
- reset_n deasserts asynchronously into the block; synchronizing the release is the responsibility of the top level.

## Structure
- Shared package dds_pkg holds:
  - PHASE_W, LUT_ADDR_W, LUT_DATA_W, SAMPLE_W;
  - the constant for the unity gain 16'hFFFF;
  - the function for the rounding shift, shared with the FM/PM readers.
- One sub-module, dds_phase_accumulator: accumulator register, clear/advance priority and address slice. It is reused by the other lookup readers.
- The multiply/round stages stay inline.

## Test plan
- Bypass check: am_enable = 0, carrier ramp −8192..8191 applied every cycle → out_data equals the input delayed by exactly 3 cycles, and ram_address stays 0.
- Constant envelope: RAM filled with 16'h8000, car_data = 8191 → out_data = 4096. Same setup with car_data = −8192 → out_data = −4096.
- Address stepping: table[i] = i, phase_inc = 2^22 → ram_address steps 0,1,2,… once per valid. Wrap check: after 1024 samples the address reads 0 again and the gain sequence restarts.
- Clear and gaps: phase_clr on the same cycle as the 5th valid → the 5th sample uses address 4, and the 6th uses address 0. Bubble check: a pattern of one valid then two idle cycles → out_valid shows the same pattern, offset by 3 cycles.
- Reset mid-stream: reset_n pulsed low with 3 samples in flight → out_valid goes 0 immediately and no stale sample emerges after release. After release, acc = 0 and the first sample reads address 0.
